// File: rtl/ex_mem_wb_pipe_if.sv
// Data-memory bus between the pipeline back half and the data memory.
//   mem_addr_o  : EX/MEM ALU result used as the memory address
//   mem_wdata_o : EX/MEM store operand
//   mem_we_o    : write strobe
//   mem_re_o    : read strobe
//   mem_rdata_i : read data, combinational from mem_addr_o
// master = pipeline side, slave = memory side.
interface ex_mem_wb_pipe_if #(
   parameter int DATA_W = 32
);
   logic [DATA_W-1:0] mem_addr_o;
   logic [DATA_W-1:0] mem_wdata_o;
   logic              mem_we_o;
   logic              mem_re_o;
   logic [DATA_W-1:0] mem_rdata_i;

   modport master (
      output mem_addr_o, mem_wdata_o, mem_we_o, mem_re_o,
      input  mem_rdata_i
   );

   modport slave (
      input  mem_addr_o, mem_wdata_o, mem_we_o, mem_re_o,
      output mem_rdata_i
   );
endinterface

// File: rtl/ex_mem_wb_pipe.sv
// Back half of the 5-stage pipeline: EX/MEM and MEM/WB registers.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   stall_i, flush_i      : hold EX/MEM (bubble MEM/WB) / bubble EX/MEM
//   ex_valid_i + controls : ID/EX control bundle and EX results
//   rs/rt_addr_i          : EX operand sources for forwarding / load-use
//   mem                   : data-memory bus (master side)
//   wb_*_o                : register-file write port
//   fwd_a/b_o             : 00 regfile, 10 EX/MEM, 01 MEM/WB
//   fwd_exmem_data_o      : EX/MEM ALU result for forwarding
//   load_use_o            : load in EX/MEM feeds the EX instruction
module ex_mem_wb_pipe #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    stall_i,
   input  logic                    flush_i,
   input  logic                    ex_valid_i,
   input  logic                    reg_write_i,
   input  logic                    mem_to_reg_i,
   input  logic                    mem_write_i,
   input  logic                    mem_read_i,
   input  logic [DATA_W-1:0]       alu_result_i,
   input  logic [DATA_W-1:0]       store_data_i,
   input  logic [REG_AW-1:0]       rd_addr_i,
   input  logic [REG_AW-1:0]       rs_addr_i,
   input  logic [REG_AW-1:0]       rt_addr_i,
   ex_mem_wb_pipe_if.master        mem,
   output logic                    wb_we_o,
   output logic [REG_AW-1:0]       wb_addr_o,
   output logic [DATA_W-1:0]       wb_data_o,
   output logic [1:0]              fwd_a_o,
   output logic [1:0]              fwd_b_o,
   output logic [DATA_W-1:0]       fwd_exmem_data_o,
   output logic                    load_use_o
);

   typedef struct packed {
      logic              valid;
      logic              reg_write;
      logic              mem_to_reg;
      logic              mem_write;
      logic              mem_read;
      logic [DATA_W-1:0] alu;
      logic [DATA_W-1:0] sdata;
      logic [REG_AW-1:0] rd;
   } exmem_t;

   typedef struct packed {
      logic              valid;
      logic              reg_write;
      logic [REG_AW-1:0] rd;
      logic [DATA_W-1:0] data;
   } memwb_t;

   exmem_t em;
   memwb_t mw;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         em <= '0;
         mw <= '0;
      end else begin
         // EX/MEM: flush wins over stall; data fields hold on flush.
         if (flush_i) begin
            em.valid      <= 1'b0;
            em.reg_write  <= 1'b0;
            em.mem_to_reg <= 1'b0;
            em.mem_write  <= 1'b0;
            em.mem_read   <= 1'b0;
         end else if (!stall_i) begin
            em.valid      <= ex_valid_i;
            em.reg_write  <= reg_write_i;
            em.mem_to_reg <= mem_to_reg_i;
            em.mem_write  <= mem_write_i;
            em.mem_read   <= mem_read_i;
            em.alu        <= alu_result_i;
            em.sdata      <= store_data_i;
            em.rd         <= rd_addr_i;
         end

         // MEM/WB: a plain stall leaves the held EX/MEM entry in place, so
         // MEM/WB must take a bubble or the instruction would retire twice.
         // With flush the EX/MEM entry moves on, so MEM/WB advances.
         if (stall_i && !flush_i) begin
            mw.valid <= 1'b0;
         end else begin
            mw.valid     <= em.valid;
            mw.reg_write <= em.reg_write;
            mw.rd        <= em.rd;
            mw.data      <= em.mem_to_reg ? mem.mem_rdata_i : em.alu;
         end
      end
   end

   assign mem.mem_addr_o  = em.alu;
   assign mem.mem_wdata_o = em.sdata;
   assign mem.mem_we_o    = em.valid & em.mem_write;
   assign mem.mem_re_o    = em.valid & em.mem_read;

   assign wb_we_o   = mw.valid & mw.reg_write & (mw.rd != '0);
   assign wb_addr_o = mw.rd;
   assign wb_data_o = mw.data;

   // A load in EX/MEM has no data yet, so it can't be a forwarding source;
   // that case is reported through load_use_o instead.
   logic em_fwd_ok, mw_fwd_ok;
   assign em_fwd_ok = em.valid & em.reg_write & ~em.mem_read & (em.rd != '0);
   assign mw_fwd_ok = mw.valid & mw.reg_write & (mw.rd != '0);

   assign fwd_a_o = (em_fwd_ok && em.rd == rs_addr_i) ? 2'b10 :
                    (mw_fwd_ok && mw.rd == rs_addr_i) ? 2'b01 : 2'b00;
   assign fwd_b_o = (em_fwd_ok && em.rd == rt_addr_i) ? 2'b10 :
                    (mw_fwd_ok && mw.rd == rt_addr_i) ? 2'b01 : 2'b00;

   assign fwd_exmem_data_o = em.alu;

   assign load_use_o = em.valid & em.mem_read & (em.rd != '0) &
                       ((em.rd == rs_addr_i) | (em.rd == rt_addr_i));

endmodule

// File: tb/tb_ex_mem_wb_pipe.sv
// Testbench for ex_mem_wb_pipe: directed steps followed by random traffic,
// checked against a two-slot instruction model of the pipeline.
module tb_ex_mem_wb_pipe;
   localparam int DW = 32;
   localparam int AW = 5;

   logic          clk_i = 1'b0;
   logic          rst_i, stall_i, flush_i;
   logic          ex_valid_i, reg_write_i, mem_to_reg_i, mem_write_i, mem_read_i;
   logic [DW-1:0] alu_result_i, store_data_i;
   logic [AW-1:0] rd_addr_i, rs_addr_i, rt_addr_i;
   logic          wb_we_o, load_use_o;
   logic [AW-1:0] wb_addr_o;
   logic [DW-1:0] wb_data_o, fwd_exmem_data_o;
   logic [1:0]    fwd_a_o, fwd_b_o;

   always #5 clk_i = ~clk_i;

   ex_mem_wb_pipe_if #(.DATA_W(DW)) mbus ();

   ex_mem_wb_pipe #(.DATA_W(DW), .REG_AW(AW)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
      .ex_valid_i(ex_valid_i), .reg_write_i(reg_write_i),
      .mem_to_reg_i(mem_to_reg_i), .mem_write_i(mem_write_i),
      .mem_read_i(mem_read_i), .alu_result_i(alu_result_i),
      .store_data_i(store_data_i), .rd_addr_i(rd_addr_i),
      .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i), .mem(mbus),
      .wb_we_o(wb_we_o), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o),
      .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o),
      .fwd_exmem_data_o(fwd_exmem_data_o), .load_use_o(load_use_o)
   );

   // Model: one instruction record per stage. *_k marks whether the data
   // fields of a slot are defined (a flushed slot's data is don't-care).
   typedef struct {
      logic          v, rw, m2r, mw, mr;
      logic [DW-1:0] alu, sd, data;
      logic [AW-1:0] rd;
   } slot_t;

   slot_t em, wb;
   bit    em_k, wb_k;
   int    checks = 0;
   int    errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   function automatic logic [1:0] exp_fwd(input slot_t e, input slot_t w, input logic [AW-1:0] src);
      if (e.v && e.rw && !e.mr && e.rd != 0 && e.rd == src) return 2'b10;
      if (w.v && w.rw && w.rd != 0 && w.rd == src) return 2'b01;
      return 2'b00;
   endfunction

   task automatic check_all(input string t);
      logic lu;
      lu = em.v && em.mr && em.rd != 0 && (em.rd == rs_addr_i || em.rd == rt_addr_i);
      chk({t, ".mem_we"}, mbus.mem_we_o, em.v & em.mw);
      chk({t, ".mem_re"}, mbus.mem_re_o, em.v & em.mr);
      if (em_k) begin
         chk({t, ".mem_addr"}, mbus.mem_addr_o, em.alu);
         chk({t, ".mem_wdata"}, mbus.mem_wdata_o, em.sd);
         chk({t, ".fwd_data"}, fwd_exmem_data_o, em.alu);
      end
      chk({t, ".wb_we"}, wb_we_o, wb.v & wb.rw & (wb.rd != 0));
      if (wb_k) begin
         chk({t, ".wb_addr"}, wb_addr_o, wb.rd);
         chk({t, ".wb_data"}, wb_data_o, wb.data);
      end
      chk({t, ".fwd_a"}, fwd_a_o, exp_fwd(em, wb, rs_addr_i));
      chk({t, ".fwd_b"}, fwd_b_o, exp_fwd(em, wb, rt_addr_i));
      chk({t, ".load_use"}, load_use_o, lu);
   endtask

   // Advance the model by one clock edge using the inputs applied now.
   task automatic model_edge();
      if (rst_i) begin
         em = '{default: '0};
         wb = '{default: '0};
         em_k = 1'b1;
         wb_k = 1'b1;
      end else begin
         if (stall_i && !flush_i) begin
            wb.v = 1'b0;
            wb_k = 1'b0;
         end else begin
            wb.v    = em.v;
            wb.rw   = em.rw;
            wb.rd   = em.rd;
            wb.data = em.m2r ? mbus.mem_rdata_i : em.alu;
            wb_k    = em_k;
         end
         if (flush_i) begin
            em.v = 1'b0; em.rw = 1'b0; em.m2r = 1'b0; em.mw = 1'b0; em.mr = 1'b0;
            em_k = 1'b0;
         end else if (!stall_i) begin
            em.v = ex_valid_i; em.rw = reg_write_i; em.m2r = mem_to_reg_i;
            em.mw = mem_write_i; em.mr = mem_read_i;
            em.alu = alu_result_i; em.sd = store_data_i; em.rd = rd_addr_i;
            em_k = 1'b1;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      model_edge();
      #1;
   endtask

   task automatic drive(input logic ev, rw, m2r, mw, mr,
                        input logic [DW-1:0] alu, sd,
                        input logic [AW-1:0] rd, rs, rt);
      ex_valid_i = ev; reg_write_i = rw; mem_to_reg_i = m2r;
      mem_write_i = mw; mem_read_i = mr;
      alu_result_i = alu; store_data_i = sd;
      rd_addr_i = rd; rs_addr_i = rs; rt_addr_i = rt;
   endtask

   task automatic idle(input logic [AW-1:0] rs, rt);
      drive(0, 0, 0, 0, 0, 0, 0, 0, rs, rt);
   endtask

   initial begin
      em = '{default: '0};
      wb = '{default: '0};
      em_k = 1'b0;
      wb_k = 1'b0;
      stall_i = 1'b0;
      flush_i = 1'b0;

      // Reset with every input nonzero
      rst_i = 1'b1;
      drive(1, 1, 1, 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, 3, 3);
      mbus.mem_rdata_i = 32'hFFFF_FFFF;
      tick();
      rst_i = 1'b0;
      #1;
      chk("rst.mem_addr", mbus.mem_addr_o, 0);
      chk("rst.mem_wdata", mbus.mem_wdata_o, 0);
      chk("rst.mem_we", mbus.mem_we_o, 0);
      chk("rst.mem_re", mbus.mem_re_o, 0);
      chk("rst.wb_we", wb_we_o, 0);
      chk("rst.wb_addr", wb_addr_o, 0);
      chk("rst.wb_data", wb_data_o, 0);
      chk("rst.fwd_a", fwd_a_o, 0);
      chk("rst.fwd_b", fwd_b_o, 0);
      chk("rst.fwd_data", fwd_exmem_data_o, 0);
      chk("rst.load_use", load_use_o, 0);
      check_all("rst");

      // ALU op: two edges to the register file
      drive(1, 1, 0, 0, 0, 32'h1234, 0, 3, 0, 0);
      tick();
      idle(0, 0);
      #1;
      chk("alu.mem_addr", mbus.mem_addr_o, 32'h1234);
      check_all("alu1");
      tick();
      chk("alu.wb_we", wb_we_o, 1);
      chk("alu.wb_addr", wb_addr_o, 3);
      chk("alu.wb_data", wb_data_o, 32'h1234);
      check_all("alu2");

      // Load with dependent EX instruction
      drive(1, 1, 1, 0, 1, 32'h80, 0, 5, 0, 0);
      tick();
      idle(5, 0);
      mbus.mem_rdata_i = 32'hCAFE;
      #1;
      chk("ld.mem_re", mbus.mem_re_o, 1);
      chk("ld.load_use", load_use_o, 1);
      chk("ld.fwd_a", fwd_a_o, 2'b00);
      check_all("ld1");
      tick();
      chk("ld.mem_re_off", mbus.mem_re_o, 0);
      chk("ld.wb_we", wb_we_o, 1);
      chk("ld.wb_data", wb_data_o, 32'hCAFE);
      check_all("ld2");

      // Forward priority: both stages write r7
      drive(1, 1, 0, 0, 0, 32'h7A, 0, 7, 0, 0);
      tick();
      drive(1, 1, 0, 0, 0, 32'h7B, 0, 7, 0, 0);
      tick();
      idle(0, 7);
      #1;
      chk("fwd.prio_b", fwd_b_o, 2'b10);
      chk("fwd.r0_a", fwd_a_o, 2'b00);
      check_all("fwd1");
      drive(1, 1, 0, 0, 0, 32'h0, 0, 0, 0, 7);
      tick();
      #1;
      chk("fwd.rd0_a", fwd_a_o, 2'b00);
      chk("fwd.wb_b", fwd_b_o, 2'b01);
      check_all("fwd2");

      // Store held by a 3-cycle stall, then flush+stall
      drive(1, 0, 0, 1, 0, 32'h40, 32'h55, 0, 0, 0);
      tick();
      drive(1, 1, 0, 0, 0, 32'h99, 0, 4, 0, 0);
      stall_i = 1'b1;
      #1;
      check_all("st0");
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("st.mem_we_held", mbus.mem_we_o, 1);
         chk("st.wb_bubble", wb_we_o, 0);
         check_all("st");
      end
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      stall_i = 1'b0;
      #1;
      chk("fl.mem_we", mbus.mem_we_o, 0);
      check_all("fl");

      // Reset while a write to r9 is pending in MEM/WB
      drive(1, 1, 0, 0, 0, 32'h9999, 0, 9, 0, 0);
      tick();
      idle(0, 0);
      tick();
      chk("r9.wb_we", wb_we_o, 1);
      chk("r9.wb_addr", wb_addr_o, 9);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      #1;
      chk("r9.wb_we_rst", wb_we_o, 0);
      check_all("r9");

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         logic [1:0] kind;
         logic       ev;
         rst_i   = ($urandom_range(0, 99) < 3);
         flush_i = ($urandom_range(0, 99) < 12);
         stall_i = ($urandom_range(0, 99) < 25);
         ev      = ($urandom_range(0, 3) != 0);
         kind    = 2'($urandom_range(0, 2));
         drive(ev, kind != 2'd2, kind == 2'd1, kind == 2'd2, kind == 2'd1,
               $urandom, $urandom,
               AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
               AW'($urandom_range(0, 7)));
         mbus.mem_rdata_i = $urandom;
         #1;
         check_all("rnd");
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ex_mem_wb_pipe.md
Name: ex_mem_wb_pipe

Overview:
Back half of the 5-stage pipeline. It consumes the ID/EX control bundle (RegWrite, MemtoReg, MemWrite, MemRead) together with the EX results, and registers them through the EX/MEM and MEM/WB stages. It drives the data-memory and register-file write ports. It also produces forwarding selects and a load-use hazard flag for the EX stage.

Parameters:
DATA_W, 32, datapath width
REG_AW, 5, register address width

Ports:
clk_i  in  1  clock, all state updates on posedge
rst_i  in  1  synchronous active-high reset
stall_i  in  1  hold EX/MEM; insert bubble into MEM/WB
flush_i  in  1  insert bubble into EX/MEM
ex_valid_i  in  1  EX stage holds a real instruction
reg_write_i  in  1  ID/EX RegWrite
mem_to_reg_i  in  1  ID/EX MemtoReg
mem_write_i  in  1  ID/EX MemWrite
mem_read_i  in  1  ID/EX MemRead
alu_result_i  in  DATA_W  EX ALU result / memory address
store_data_i  in  DATA_W  EX store operand
rd_addr_i  in  REG_AW  EX destination register
rs_addr_i  in  REG_AW  EX operand A source register
rt_addr_i  in  REG_AW  EX operand B source register
mem_rdata_i  in  DATA_W  data-memory read data (combinational from mem_addr_o)
mem_addr_o  out  DATA_W  EX/MEM ALU result
mem_wdata_o  out  DATA_W  EX/MEM store data
mem_we_o  out  1  memory write strobe
mem_re_o  out  1  memory read strobe
wb_we_o  out  1  register-file write enable
wb_addr_o  out  REG_AW  register-file write address
wb_data_o  out  DATA_W  register-file write data
fwd_a_o  out  2  operand A select: 00 regfile, 10 EX/MEM, 01 MEM/WB
fwd_b_o  out  2  operand B select, same encoding
fwd_exmem_data_o  out  DATA_W  equals mem_addr_o
load_use_o  out  1  EX/MEM holds a load whose rd matches rs or rt

Behaviour:
- Clocking: one clock. Reset is synchronous and active-high. Priority: rst_i > flush_i > stall_i > normal advance.
- Reset: both stage valid bits, all control bits, addresses and data clear to 0. All outputs read 0 in the cycle after the reset edge.
- EX/MEM register, normal advance: captures all *_i fields; valid <= ex_valid_i.
- EX/MEM on flush_i: valid and controls <= 0; data fields don't-care, implementation holds them.
- EX/MEM on stall_i without flush_i: holds all fields.
- MEM/WB register, normal advance (also when flush_i=1): valid <= EX/MEM valid; reg_write and rd copied; data <= mem_to_reg ? mem_rdata_i : EX/MEM alu_result, selected at capture.
- MEM/WB on stall_i without flush_i: valid <= 0 (bubble).
- mem_we_o = EX/MEM valid & mem_write. mem_re_o = EX/MEM valid & mem_read. Both are combinational from the register, never from inputs.
- wb_we_o = MEM/WB valid & reg_write & (wb_addr_o != 0). Writes to r0 are suppressed.
- Latency: an instruction captured at edge N drives memory during cycle N..N+1 and the register file after edge N+1 (2 edges total, absent stalls).
- Forwarding, per operand src in {rs, rt}:
  - 10 if EX/MEM valid & reg_write & ~mem_read & rd != 0 & rd == src;
  - else 01 if MEM/WB valid & reg_write & rd != 0 & rd == src;
  - else 00.
  - EX/MEM has priority when both match.
- load_use_o = EX/MEM valid & mem_read & rd != 0 & (rd == rs_addr_i | rd == rt_addr_i). Combinational.
- Boundary: a stalled load stays in EX/MEM, and mem_re_o stays high for the whole stall. Reset asserted mid-stall discards both stages. Simultaneous flush and stall gives an EX/MEM bubble while MEM/WB advances.

Test Plan:
- Reset: rst_i=1 one edge with inputs nonzero -> every output 0; wb_we_o=0; fwd_a_o=fwd_b_o=00.
- ALU op flow: rd=3, reg_write=1, alu_result=0x1234 at edge 1 -> mem_addr_o=0x1234 after edge 1. After edge 2: wb_we_o=1, wb_addr_o=3, wb_data_o=0x1234.
- Load: mem_read=1, mem_to_reg=1, rd=5, mem_rdata_i=0xCAFE -> mem_re_o=1 for one cycle; wb_data_o=0xCAFE after edge 2. With rs_addr_i=5 while the load is in EX/MEM: load_use_o=1 and fwd_a_o=00.
- Forward priority: EX/MEM rd=7 (ALU) and MEM/WB rd=7, rt_addr_i=7 -> fwd_b_o=10. EX/MEM rd=0 with rs=0 -> fwd_a_o=00.
- Stall/flush: store in EX/MEM with stall_i=1 for 3 cycles -> mem_we_o held 1 and MEM/WB bubbles (wb_we_o=0). flush_i=1 together with stall_i -> mem_we_o=0 next cycle.
- Reset mid-operation: rst_i during a pending MEM/WB write to r9 -> wb_we_o=0 the next cycle; no write to r9.
